// File: rtl/clk_div_pkg.sv
// Shared constants for the two-stage board-clock divider.
// Also holds the helper that checks a half-period fits its counter.
package clk_div_pkg;

    localparam int CLKIN_HZ = 50_000_000;
    localparam int HALF1    = 2500;
    localparam int HALF2    = 10;
    localparam int CNT1_W   = 13;
    localparam int CNT2_W   = 4;

    // A half period of HALF needs terminal value HALF-1 to fit in width bits.
    function automatic bit half_fits(input int half, input int width);
        return (half >= 1) && (half <= (1 << width));
    endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One divider stage: counts enabled edges and toggles q at each terminal count.
// tick marks the enabled edge on which the counter wraps.
module clk_div_stage
    import clk_div_pkg::*;
#(
    parameter int HALF  = 2500,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             q,
    output logic             tick
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(HALF - 1);

    if (!half_fits(HALF, WIDTH)) begin : g_bad_half
        $error("clk_div_stage: HALF does not fit in WIDTH bits");
    end

    // Anything at or past terminal wraps, so a corrupted count self-recovers.
    assign tick = en && (cnt >= TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            q   <= ~q;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div.sv
// 50 MHz board clock to 10 kHz and 1 kHz square waves, all in the clkin domain.
// Stage 2 only advances on the stage-1 wrap, keeping both outputs edge-aligned.
module clk_div
    import clk_div_pkg::*;
(
    input  logic clkin,
    input  logic clrn,
    output logic clk_10kHz,
    output logic clk_1kHz
);

    logic [CNT1_W-1:0] count1;
    logic [CNT2_W-1:0] count2;
    logic              tick1;
    logic              tick2_unused;

    clk_div_stage #(
        .HALF  (HALF1),
        .WIDTH (CNT1_W)
    ) u_stage1 (
        .clk   (clkin),
        .rst_n (clrn),
        .en    (1'b1),
        .cnt   (count1),
        .q     (clk_10kHz),
        .tick  (tick1)
    );

    clk_div_stage #(
        .HALF  (HALF2),
        .WIDTH (CNT2_W)
    ) u_stage2 (
        .clk   (clkin),
        .rst_n (clrn),
        .en    (tick1),
        .cnt   (count2),
        .q     (clk_1kHz),
        .tick  (tick2_unused)
    );

endmodule

// File: tb/tb_clk_div.sv
// Randomized-reset bench for clk_div against an arithmetic model of elapsed edges.
// Model: after n counted edges, every output is a plain div/mod of n.
module tb_clk_div;

    localparam int H1 = 2500;
    localparam int H2 = 10;

    logic clkin = 1'b0;
    logic clrn  = 1'b0;
    logic clk_10kHz;
    logic clk_1kHz;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_edge = 0;
    logic prev_10k = 1'b0;
    logic prev_1k  = 1'b0;

    clk_div dut (
        .clkin     (clkin),
        .clrn      (clrn),
        .clk_10kHz (clk_10kHz),
        .clk_1kHz  (clk_1kHz)
    );

    always #10 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, n_edge, obs, exp);
        end
    endtask

    // One clkin edge: advance the model, then compare on the falling edge.
    task automatic step();
        logic [31:0] exp_c1, exp_c2, exp_10k, exp_1k;
        @(posedge clkin);
        if (!clrn) n_edge = 0;
        else       n_edge++;
        @(negedge clkin);
        exp_c1  = 32'(n_edge % H1);
        exp_c2  = 32'((n_edge / H1) % H2);
        exp_10k = 32'((n_edge / H1) % 2);
        exp_1k  = 32'((n_edge / (H1 * H2)) % 2);
        check("count1",    32'(dut.count1), exp_c1);
        check("count2",    32'(dut.count2), exp_c2);
        check("clk_10kHz", 32'(clk_10kHz),  exp_10k);
        check("clk_1kHz",  32'(clk_1kHz),   exp_1k);
        if (clk_10kHz && !prev_10k)
            check("10k_rise_phase", 32'(n_edge % (2 * H1)), 32'(H1));
        if (clk_1kHz && !prev_1k)
            check("1k_rise_phase", 32'(n_edge % (2 * H1 * H2)), 32'(H1 * H2));
        if (clk_1kHz !== prev_1k) begin
            check("align_10k_toggle", 32'(clk_10kHz ^ prev_10k), 32'd1);
            check("align_count1",     32'(dut.count1), 32'd0);
        end
        prev_10k = clk_10kHz;
        prev_1k  = clk_1kHz;
    endtask

    task automatic run(input int edges);
        for (int i = 0; i < edges; i++) step();
    endtask

    task automatic hold_reset(input int edges);
        clrn = 1'b0;
        run(edges);
        clrn = 1'b1;
    endtask

    initial begin
        int len;
        // Reset hold, then long run past the first full 1 kHz period.
        hold_reset(5);
        run(50_010);

        // Mid-run reset at edge 13000, then watch the restart.
        hold_reset(1);
        run(13_000);
        check("mid_count1", 32'(dut.count1), 32'd500);
        check("mid_count2", 32'(dut.count2), 32'd5);
        check("mid_10k",    32'(clk_10kHz),  32'd1);
        hold_reset(1);
        check("mid_clear_count1", 32'(dut.count1), 32'd0);
        check("mid_clear_10k",    32'(clk_10kHz),  32'd0);
        run(2_600);

        // Randomized reset points and reset lengths.
        for (int k = 0; k < 3; k++) begin
            hold_reset(int'($urandom_range(1, 4)));
            len = int'($urandom_range(100, 4000));
            run(len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
